// File: rtl/rr_arb4_sel.sv
// Four-way round-robin arbiter driving {s1,s0} of a downstream 2-to-4 decoder.
// Define RR_TIMEOUT_EN to add a grant-hold watchdog bounded by HOLD_MAX cycles.
module rr_arb4_sel #(
   parameter int HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic       s0,
   output logic       s1,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_nxt;
   logic [1:0] sel, sel_nxt;
   logic [1:0] lp, lp_nxt;
   logic [1:0] win;
   logic       to_nxt;

   // Search lp+3 down to lp+1 so the nearest requester after lp is written last.
   always_comb begin
      win = lp;
      for (int k = 3; k >= 1; k--) begin
         if (req[lp + 2'(k)]) win = lp + 2'(k);
      end
   end

`ifdef RR_TIMEOUT_EN
   localparam int CW = $clog2(HOLD_MAX + 1);
   logic [CW-1:0] cnt, cnt_nxt;
   logic          hit;

   // Releasing on the edge where the count would reach HOLD_MAX gives HOLD_MAX grant cycles.
   assign hit = (cnt == CW'(HOLD_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end
`endif

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      lp_nxt    = lp;
      to_nxt    = 1'b0;
`ifdef RR_TIMEOUT_EN
      cnt_nxt   = cnt;
`endif
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               sel_nxt   = win;
               lp_nxt    = win;
`ifdef RR_TIMEOUT_EN
               cnt_nxt   = '0;
`endif
            end
         end
         GRANT: begin
            if (done) begin
               state_nxt = IDLE;
`ifdef RR_TIMEOUT_EN
            end else if (hit) begin
               state_nxt = IDLE;
               to_nxt    = 1'b1;
            end else begin
               cnt_nxt   = cnt + CW'(1);
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sel     <= 2'd0;
         lp      <= 2'd3;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         lp      <= lp_nxt;
         timeout <= to_nxt;
      end
   end

   // Decoded straight from the state register so reset clears it without a clock.
   assign gnt_valid = (state == GRANT);
   assign s0        = sel[0];
   assign s1        = sel[1];

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Directed bench for rr_arb4_sel: vector table plus hold, watchdog and async-reset sequences.
module tb_rr_arb4_sel;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic       s0, s1, gnt_valid, timeout;

   int total = 0;
   int bad   = 0;

   rr_arb4_sel #(.HOLD_MAX(15)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .s0(s0), .s1(s1), .gnt_valid(gnt_valid), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       done;
      logic [1:0] s;
      logic       v;
   } vec_t;

   vec_t tbl[25];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
   endtask

   task automatic set(input int i, input logic [3:0] r, input logic d,
                      input logic [1:0] s, input logic v);
      tbl[i].req = r; tbl[i].done = d; tbl[i].s = s; tbl[i].v = v;
   endtask

   initial begin
      logic [3:0] dec, dec_exp;
      int         n;
      logic       seen_to;

      // Round robin 0,1,2,3,0; wrap from 2 past 3; lone requester; idle done; grant hold.
      set( 0, 4'b1111, 1'b0, 2'd0, 1'b1);
      set( 1, 4'b1111, 1'b1, 2'd0, 1'b0);
      set( 2, 4'b1111, 1'b0, 2'd1, 1'b1);
      set( 3, 4'b1111, 1'b1, 2'd1, 1'b0);
      set( 4, 4'b1111, 1'b0, 2'd2, 1'b1);
      set( 5, 4'b1111, 1'b1, 2'd2, 1'b0);
      set( 6, 4'b1111, 1'b0, 2'd3, 1'b1);
      set( 7, 4'b1111, 1'b1, 2'd3, 1'b0);
      set( 8, 4'b1111, 1'b0, 2'd0, 1'b1);
      set( 9, 4'b1111, 1'b1, 2'd0, 1'b0);
      set(10, 4'b0100, 1'b0, 2'd2, 1'b1);
      set(11, 4'b0101, 1'b1, 2'd2, 1'b0);
      set(12, 4'b0101, 1'b0, 2'd0, 1'b1);
      set(13, 4'b0101, 1'b1, 2'd0, 1'b0);
      set(14, 4'b0010, 1'b0, 2'd1, 1'b1);
      set(15, 4'b0010, 1'b1, 2'd1, 1'b0);
      set(16, 4'b0010, 1'b0, 2'd1, 1'b1);
      set(17, 4'b0010, 1'b1, 2'd1, 1'b0);
      set(18, 4'b0000, 1'b1, 2'd1, 1'b0);
      set(19, 4'b0000, 1'b0, 2'd1, 1'b0);
      set(20, 4'b1000, 1'b0, 2'd3, 1'b1);
      set(21, 4'b0001, 1'b0, 2'd3, 1'b1);
      set(22, 4'b0000, 1'b0, 2'd3, 1'b1);
      set(23, 4'b0000, 1'b1, 2'd3, 1'b0);
      set(24, 4'b0000, 1'b0, 2'd3, 1'b0);

      rst  = 1'b1;
      req  = 4'b1111;
      done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid", int'(gnt_valid), 0);
      chk("reset_sel", int'({s1, s0}), 0);
      chk("reset_timeout", int'(timeout), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].req, tbl[i].done);
         chk($sformatf("vec%0d_sel", i), int'({s1, s0}), int'(tbl[i].s));
         chk($sformatf("vec%0d_valid", i), int'(gnt_valid), int'(tbl[i].v));
         chk($sformatf("vec%0d_timeout", i), int'(timeout), 0);
         dec     = gnt_valid ? (4'b0001 << {s1, s0}) : 4'b0000;
         dec_exp = tbl[i].v ? (4'b0001 << tbl[i].s) : 4'b0000;
         chk($sformatf("vec%0d_decode", i), int'(dec), int'(dec_exp));
      end

      // Grantee drops req with no done: held forever, or until the watchdog fires.
      step(4'b0001, 1'b0);
      chk("hold_grant_sel", int'({s1, s0}), 0);
      req     = 4'b0000;
      n       = 1;
      seen_to = 1'b0;
      while (gnt_valid && n < 40) begin
         chk("hold_timeout_low", int'(timeout), 0);
         step(4'b0000, 1'b0);
         if (gnt_valid) n++;
      end
`ifdef RR_TIMEOUT_EN
      chk("hold_cycles", n, 15);
      chk("hold_valid_fell", int'(gnt_valid), 0);
      chk("timeout_pulse", int'(timeout), 1);
      step(4'b0000, 1'b0);
      chk("timeout_single", int'(timeout), 0);
      // done on the watchdog edge wins: no timeout pulse.
      step(4'b0010, 1'b0);
      chk("coincide_grant", int'(gnt_valid), 1);
      for (int k = 0; k < 14; k++) step(4'b0000, 1'b0);
      chk("coincide_still_held", int'(gnt_valid), 1);
      step(4'b0000, 1'b1);
      chk("coincide_valid", int'(gnt_valid), 0);
      chk("coincide_timeout", int'(timeout), 0);
`else
      chk("hold_cycles", n, 40);
      chk("hold_valid", int'(gnt_valid), 1);
      step(4'b0000, 1'b1);
      chk("hold_release", int'(gnt_valid), 0);
      chk("hold_no_timeout", int'(timeout), 0);
`endif

      // Async reset mid-grant clears outputs before any clock edge.
      step(4'b0100, 1'b0);
      chk("pre_rst_valid", int'(gnt_valid), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(gnt_valid), 0);
      chk("async_rst_sel", int'({s1, s0}), 0);
      @(negedge clk);
      rst = 1'b0;
      step(4'b1000, 1'b0);
      chk("post_rst_sel", int'({s1, s0}), 3);
      chk("post_rst_valid", int'(gnt_valid), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1);
   end

endmodule
